// File: rtl/mem_stall_bridge.sv
// mem_stall_bridge: turns multicycle-controller memory strobes into single
// bus transactions, stalling the controller until the bus acks or times out.
module mem_stall_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iRwrite,
    input  logic              memWrite,
    input  logic              memRead,
    input  logic              IorD,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mdr,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {K_FETCH, K_WRITE, K_READ} kind_t;
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
    state_t            state;
    kind_t             kind;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              request;
    always_comb begin
        request   = iRwrite | memWrite | memRead;
        stall     = !rst && ((state == IDLE && request) || state == BUSY);
        bus_req   = !rst && state == BUSY;
        bus_we    = bus_req && kind == K_WRITE;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            kind    <= K_FETCH;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            instr   <= '0;
            mdr     <= '0;
            bus_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (request) begin
                    state   <= BUSY;
                    cnt     <= '0;
                    kind    <= iRwrite ? K_FETCH : memWrite ? K_WRITE : K_READ;
                    addr_q  <= (iRwrite || !IorD) ? pc : alu_out;
                    wdata_q <= wdata;
                end
                BUSY: if (bus_ack) begin
                    // An ack on the limit cycle still completes normally.
                    if (kind == K_FETCH) instr <= bus_rdata;
                    if (kind == K_READ) mdr <= bus_rdata;
                    state <= DONE;
                end else if (cnt == LIMIT) begin
                    bus_err <= 1'b1;
                    state   <= DONE;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                DONE: begin
                    bus_err <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stall_bridge.sv
// tb_mem_stall_bridge: directed checks of the stall bridge with a controller
// that holds strobes while stalled and a bus that acks on a chosen cycle.
module tb_mem_stall_bridge;
    logic        clk = 0, rst = 1;
    logic        iRwrite = 0, memWrite = 0, memRead = 0, IorD = 0;
    logic [31:0] pc = 0, alu_out = 0, wdata = 0;
    logic        stall, bus_err, bus_req, bus_we, bus_ack = 0;
    logic [31:0] instr, mdr, bus_addr, bus_wdata, bus_rdata = 0;
    int          checks = 0, errors = 0;
    int          ns, nreq, nerr, ntx;
    logic        unstable, prev_req, cap_we;
    logic [31:0] cap_addr, cap_wdata;

    mem_stall_bridge dut (
        .clk(clk), .rst(rst), .iRwrite(iRwrite), .memWrite(memWrite), .memRead(memRead),
        .IorD(IorD), .pc(pc), .alu_out(alu_out), .wdata(wdata), .stall(stall),
        .instr(instr), .mdr(mdr), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction for 24 cycles; ack_at = BUSY cycle to ack in (0 = never),
    // hold = extra cycles the controller keeps its strobe after stall drops.
    task automatic txn(input int ack_at, input logic [31:0] rd, input int hold);
        logic drop_next;
        ns = 0; nreq = 0; nerr = 0; ntx = 0; unstable = 0; prev_req = 0; drop_next = 0;
        for (int c = 0; c < 24; c++) begin
            if (drop_next) begin
                {iRwrite, memWrite, memRead} = 3'b000;
                drop_next = 0;
            end
            #1;
            if (stall) ns++;
            if (bus_err) nerr++;
            if (bus_req) begin
                nreq++;
                if (!prev_req) ntx++;
                if (nreq == 1) begin
                    cap_addr = bus_addr; cap_we = bus_we; cap_wdata = bus_wdata;
                end else if (bus_addr !== cap_addr || bus_we !== cap_we || bus_wdata !== cap_wdata)
                    unstable = 1;
                bus_ack = (nreq == ack_at);
                bus_rdata = rd;
            end else bus_ack = 0;
            prev_req = bus_req;
            if (c > 0 && !stall && (iRwrite | memWrite | memRead)) begin
                if (hold > 0) begin
                    hold--;
                    drop_next = 1;
                end else {iRwrite, memWrite, memRead} = 3'b000;
            end
            step();
        end
    endtask

    initial begin
        step();
        iRwrite = 1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_bus_req", bus_req, 0);
        step();
        chk("rst_instr", instr, 0);
        chk("rst_mdr", mdr, 0);
        chk("rst_bus_err", bus_err, 0);
        iRwrite = 0; rst = 0;
        step();
        chk("idle_stall", stall, 0);

        bus_ack = 1; bus_rdata = 32'h0000_0BAD;
        step();
        bus_ack = 0;
        step();
        chk("idle_ack_mdr", mdr, 0);
        chk("idle_ack_instr", instr, 0);

        pc = 32'h40; IorD = 1; alu_out = 32'h999; iRwrite = 1;
        txn(3, 32'h2008_0005, 0);
        chk("fetch_stall", ns, 4);
        chk("fetch_req", nreq, 3);
        chk("fetch_addr", cap_addr, 32'h40);
        chk("fetch_we", cap_we, 0);
        chk("fetch_instr", instr, 32'h2008_0005);
        chk("fetch_mdr", mdr, 0);
        chk("fetch_err", nerr, 0);
        chk("fetch_stable", unstable, 0);

        pc = 32'h44; IorD = 1; alu_out = 32'h100; wdata = 32'hDEAD_BEEF; memWrite = 1;
        txn(1, 32'h55, 0);
        chk("store_stall", ns, 2);
        chk("store_we", cap_we, 1);
        chk("store_addr", cap_addr, 32'h100);
        chk("store_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("store_instr", instr, 32'h2008_0005);
        chk("store_mdr", mdr, 0);

        pc = 32'h80; IorD = 0; memRead = 1;
        txn(0, 32'h77, 0);
        chk("tmo_req", nreq, 16);
        chk("tmo_err", nerr, 1);
        chk("tmo_stall", ns, 17);
        chk("tmo_addr", cap_addr, 32'h80);
        chk("tmo_mdr", mdr, 0);
        chk("tmo_stable", unstable, 0);
        chk("tmo_idle_req", bus_req, 0);
        chk("tmo_idle_stall", stall, 0);

        IorD = 1; alu_out = 32'h200; memRead = 1;
        txn(16, 32'h1234_5678, 0);
        chk("lim_mdr", mdr, 32'h1234_5678);
        chk("lim_err", nerr, 0);
        chk("lim_req", nreq, 16);
        chk("lim_stall", ns, 17);

        pc = 32'h48; IorD = 1; alu_out = 32'h300; wdata = 32'h1;
        {iRwrite, memWrite, memRead} = 3'b111;
        txn(1, 32'h8C00_0000, 0);
        chk("prio_we", cap_we, 0);
        chk("prio_addr", cap_addr, 32'h48);
        chk("prio_instr", instr, 32'h8C00_0000);
        chk("prio_mdr", mdr, 32'h1234_5678);
        chk("prio_tx", ntx, 1);

        pc = 32'h50; IorD = 0; memRead = 1;
        txn(2, 32'hCAFE_F00D, 1);
        chk("hold_tx", ntx, 1);
        chk("hold_req", nreq, 2);
        chk("hold_mdr", mdr, 32'hCAFE_F00D);

        pc = 32'h60; IorD = 0; memRead = 1;
        step();
        chk("rstb_busy1", bus_req, 1);
        step();
        chk("rstb_busy2", bus_req, 1);
        rst = 1; bus_ack = 1; bus_rdata = 32'hFFFF;
        #1;
        chk("rstb_stall_in_rst", stall, 0);
        chk("rstb_req_in_rst", bus_req, 0);
        step();
        rst = 0; memRead = 0; bus_ack = 0;
        #1;
        chk("rstb_req_after", bus_req, 0);
        chk("rstb_mdr", mdr, 0);
        chk("rstb_instr", instr, 0);
        chk("rstb_err", bus_err, 0);
        step();
        chk("rstb_err_next", bus_err, 0);
        chk("rstb_stall_next", stall, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stall_bridge.md
MEM_STALL_BRIDGE -- requirements
Module: mem_stall_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, bus address width.
REQ-002 Parameter DATA_W, default 32, bus data width.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles spent in BUSY before abort; legal range 2..255.
REQ-004 Clocking: one clock; reset is synchronous and active-high (clk, rst).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 iRwrite  in  1  controller fetch strobe; memory read at pc into IR.
REQ-008 memWrite  in  1  controller store strobe.
REQ-009 memRead  in  1  controller data-load strobe; memory read into MDR.
REQ-010 IorD  in  1  address select for memWrite/memRead: 0 = pc, 1 = alu_out.
REQ-011 pc  in  ADDR_W  program counter.
REQ-012 alu_out  in  ADDR_W  registered ALU result (data address).
REQ-013 wdata  in  DATA_W  store data.
REQ-014 stall  out  1  controller must freeze its state and hold strobes while high.
REQ-015 instr  out  DATA_W  instruction register (IR); opcode = instr[31:26].
REQ-016 mdr  out  DATA_W  memory data register.
REQ-017 bus_err  out  1  one-cycle pulse on timeout abort.
REQ-018 bus_req, bus_we  out  1 each  bus request / write enable.
REQ-019 bus_addr  out  ADDR_W; bus_wdata  out  DATA_W.
REQ-020 bus_ack  in  1  single-cycle completion; bus_rdata  in  DATA_W, valid with bus_ack.

Function
REQ-021 FSM states SHALL be IDLE, BUSY, DONE.
REQ-022 In IDLE, request = iRwrite | memWrite | memRead; on request, SHALL latch kind, address, wdata and go BUSY next cycle.
REQ-023 Priority on simultaneous strobes: iRwrite > memWrite > memRead; lower strobes ignored for that transaction.
REQ-024 Fetch address SHALL be pc regardless of IorD; write/read address SHALL be IorD ? alu_out : pc.
REQ-025 stall SHALL be combinational: 1 when (IDLE and request) or BUSY; 0 in DONE.
REQ-026 In BUSY: bus_req=1, bus_we=1 only for write, bus_addr/bus_wdata = latched values, stable every BUSY cycle.
REQ-027 bus_req SHALL be 0 in IDLE and DONE; bus_ack outside BUSY is ignored.
REQ-028 On bus_ack in BUSY: fetch loads instr <= bus_rdata, read loads mdr <= bus_rdata, write loads neither; go DONE next cycle.
REQ-029 DONE SHALL last exactly one cycle, ignore all strobes, then go IDLE.
REQ-030 Latency: request in cycle N with ack in first BUSY cycle (N+1) -> stall low in N+2; total stall = 2 + ack wait cycles.
REQ-031 Cycle counter SHALL clear on entering BUSY and increment each BUSY cycle without ack.
REQ-032 If no ack by the TIMEOUT-th BUSY cycle: bus_req drops next cycle, bus_err=1 for exactly the DONE cycle, instr/mdr unchanged.
REQ-033 bus_ack arriving in the same cycle as the timeout limit SHALL win: normal completion, no bus_err.
REQ-034 instr and mdr SHALL hold their values in all cycles not covered by REQ-028.

Reset
REQ-035 On rst: state IDLE, counter 0, instr=0, mdr=0, bus_err=0, latched address/data 0.
REQ-036 rst during BUSY SHALL abort: bus_req=0 the cycle after rst sampled, no IR/MDR update, no bus_err.
REQ-037 During rst, stall SHALL be 0 and bus_req 0 regardless of strobes.

Verification
REQ-038 Fetch: pc=0x0000_0040, iRwrite=1, ack after 2 BUSY cycles with rdata=0x2008_0005 -> bus_addr=0x40, bus_we=0, instr=0x2008_0005, stall high 4 cycles, mdr unchanged.
REQ-039 Store: IorD=1, alu_out=0x0000_0100, wdata=0xDEAD_BEEF, memWrite=1, immediate ack -> bus_we=1, bus_addr=0x100, bus_wdata=0xDEAD_BEEF, stall high 2 cycles.
REQ-040 Timeout: memRead=1, no ack, TIMEOUT=16 -> bus_req high 16 cycles, bus_err pulse 1 cycle, mdr unchanged, back to IDLE.
REQ-041 Ack on limit cycle: ack in 16th BUSY cycle, rdata=0x1234_5678 -> mdr=0x1234_5678, bus_err stays 0.
REQ-042 Strobe held through DONE: memRead held high one extra cycle -> exactly one bus transaction issued.
REQ-043 Reset mid-BUSY: rst asserted in 2nd BUSY cycle -> bus_req 0 next cycle, instr=mdr=0, bus_err 0.
